// File: rtl/scr_pkg.sv
// ---------------------------------------------------------------------------
// scr_pkg
// Shared definitions for the MCU scratch-RAM read and write path blocks.
//   SCR_DATA_W / SCR_ADDR_W : scratch-RAM word and address widths
//   scr_op_t                : read-request address source
//   rd_state_t              : read controller FSM state encoding
// ---------------------------------------------------------------------------
package scr_pkg;

   localparam int SCR_DATA_W = 10;
   localparam int SCR_ADDR_W = 8;

   typedef enum logic [1:0] {
      RD_IMM = 2'd0,   // address from immediate
      RD_REG = 2'd1,   // address from register value
      POP    = 2'd2,   // address = SP, then SP+1
      PEEK   = 2'd3    // address = SP, SP unchanged
   } scr_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      DLV  = 2'd2
   } rd_state_t;

endpackage : scr_pkg

// File: rtl/scr_sp_reg.sv
// ---------------------------------------------------------------------------
// scr_sp_reg
// Stack pointer register for the scratch RAM.
//   CLK, RST   : clock, synchronous active-high reset (SP -> 0)
//   i_ld/i_din : load SP (highest priority)
//   i_inc      : POP post-increment
//   i_dec      : PUSH decrement from the write path
//   o_sp       : current SP
// Increment and decrement together cancel. Arithmetic wraps modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module scr_sp_reg
   import scr_pkg::*;
#(
   parameter int ADDR_W = SCR_ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              i_ld,
   input  logic [ADDR_W-1:0] i_din,
   input  logic              i_inc,
   input  logic              i_dec,
   output logic [ADDR_W-1:0] o_sp
);

   logic [ADDR_W-1:0] r_sp;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sp <= '0;
      end else if (i_ld) begin
         r_sp <= i_din;
      end else if (i_inc && !i_dec) begin
         r_sp <= r_sp + 1'b1;
      end else if (i_dec && !i_inc) begin
         r_sp <= r_sp - 1'b1;
      end
   end

   assign o_sp = r_sp;

endmodule : scr_sp_reg

// File: rtl/scr_read_ctrl.sv
// ---------------------------------------------------------------------------
// scr_read_ctrl
// Read-side controller for the MCU scratch RAM. Accepts a read request,
// forms the address (immediate, register or SP), issues a one-cycle
// synchronous read and delivers the returned word to one of four
// destinations with a one-hot valid pulse. Owns the stack pointer.
//
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   REQ, REQ_OP, REQ_DEST : request, address source, destination index
//   IMM_ADDR, REG_ADDR  : candidate read addresses
//   SP_LD, SP_DIN       : SP load
//   SP_DECR             : PUSH decrement strobe from the write path
//   SCR_ADDR, SCR_RE    : registered RAM read address / enable
//   SCR_DATA            : RAM read data, valid the cycle after SCR_RE
//   DOUT, DOUT_VLD      : delivered word and one-hot destination pulse
//   BUSY                : high in RD and DLV (requests ignored)
//   SP_OUT              : current stack pointer
//   DBG_STATE           : FSM state for observation
//
// Handshake: REQ is a request accepted only on an edge where the FSM is in
// IDLE; BUSY low means the next edge will sample REQ. DOUT_VLD is a
// single-cycle, unconditionally accepted pulse (no ready from consumers).
// ---------------------------------------------------------------------------
module scr_read_ctrl
   import scr_pkg::*;
#(
   parameter int DATA_W = SCR_DATA_W,
   parameter int ADDR_W = SCR_ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ,
   input  logic [1:0]        REQ_OP,
   input  logic [1:0]        REQ_DEST,
   input  logic [ADDR_W-1:0] IMM_ADDR,
   input  logic [ADDR_W-1:0] REG_ADDR,
   input  logic              SP_LD,
   input  logic [ADDR_W-1:0] SP_DIN,
   input  logic              SP_DECR,
   output logic [ADDR_W-1:0] SCR_ADDR,
   output logic              SCR_RE,
   input  logic [DATA_W-1:0] SCR_DATA,
   output logic [DATA_W-1:0] DOUT,
   output logic [3:0]        DOUT_VLD,
   output logic              BUSY,
   output logic [ADDR_W-1:0] SP_OUT,
   output logic [1:0]        DBG_STATE
);

   rd_state_t         r_state;
   scr_op_t           r_op;
   logic [1:0]        r_dest;
   logic [ADDR_W-1:0] r_scr_addr;
   logic              r_scr_re;
   logic [DATA_W-1:0] r_dout;
   logic [3:0]        r_dout_vld;
   logic              r_busy;

   logic [ADDR_W-1:0] w_sp;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_sp_inc;

   // POP and PEEK both read at the SP value seen in IDLE.
   always_comb begin
      w_sel_addr = IMM_ADDR;
      case (scr_op_t'(REQ_OP))
         RD_IMM:  w_sel_addr = IMM_ADDR;
         RD_REG:  w_sel_addr = REG_ADDR;
         POP:     w_sel_addr = w_sp;
         PEEK:    w_sel_addr = w_sp;
         default: w_sel_addr = IMM_ADDR;
      endcase
   end

   // POP's post-increment lands on the edge that leaves RD.
   assign w_sp_inc = (r_state == RD) && (r_op == POP);

   scr_sp_reg #(.ADDR_W(ADDR_W)) u_sp (
      .CLK   (CLK),
      .RST   (RST),
      .i_ld  (SP_LD),
      .i_din (SP_DIN),
      .i_inc (w_sp_inc),
      .i_dec (SP_DECR),
      .o_sp  (w_sp)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_op       <= RD_IMM;
         r_dest     <= 2'd0;
         r_scr_addr <= '0;
         r_scr_re   <= 1'b0;
         r_dout     <= '0;
         r_dout_vld <= 4'b0000;
         r_busy     <= 1'b0;
      end else begin
         // Valid is a single-cycle pulse unless DLV sets it below.
         r_dout_vld <= 4'b0000;
         case (r_state)
            IDLE: begin
               if (REQ) begin
                  r_op       <= scr_op_t'(REQ_OP);
                  r_dest     <= REQ_DEST;
                  r_scr_addr <= w_sel_addr;
                  r_scr_re   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= RD;
               end
            end
            RD: begin
               r_scr_re <= 1'b0;
               r_state  <= DLV;
            end
            DLV: begin
               r_dout     <= SCR_DATA;
               r_dout_vld <= 4'b0001 << r_dest;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: begin
               r_scr_re <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign SCR_ADDR  = r_scr_addr;
   assign SCR_RE    = r_scr_re;
   assign DOUT      = r_dout;
   assign DOUT_VLD  = r_dout_vld;
   assign BUSY      = r_busy;
   assign SP_OUT    = w_sp;
   assign DBG_STATE = r_state;

endmodule : scr_read_ctrl

// File: tb/tb_scr_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scr_read_ctrl
// Directed bench for scr_read_ctrl with a scratch-RAM model, an expected
// delivery queue and a monitor that checks every DOUT_VLD pulse.
// ---------------------------------------------------------------------------
module tb_scr_read_ctrl;

   localparam int DW = 10;
   localparam int AW = 8;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   // ---------------- DUT signals ----------------
   logic          REQ = 1'b0;
   logic [1:0]    REQ_OP = 2'd0;
   logic [1:0]    REQ_DEST = 2'd0;
   logic [AW-1:0] IMM_ADDR = '0;
   logic [AW-1:0] REG_ADDR = '0;
   logic          SP_LD = 1'b0;
   logic [AW-1:0] SP_DIN = '0;
   logic          SP_DECR = 1'b0;
   logic [AW-1:0] SCR_ADDR;
   logic          SCR_RE;
   logic [DW-1:0] SCR_DATA = '0;
   logic [DW-1:0] DOUT;
   logic [3:0]    DOUT_VLD;
   logic          BUSY;
   logic [AW-1:0] SP_OUT;
   logic [1:0]    DBG_STATE;

   scr_read_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ       (REQ),
      .REQ_OP    (REQ_OP),
      .REQ_DEST  (REQ_DEST),
      .IMM_ADDR  (IMM_ADDR),
      .REG_ADDR  (REG_ADDR),
      .SP_LD     (SP_LD),
      .SP_DIN    (SP_DIN),
      .SP_DECR   (SP_DECR),
      .SCR_ADDR  (SCR_ADDR),
      .SCR_RE    (SCR_RE),
      .SCR_DATA  (SCR_DATA),
      .DOUT      (DOUT),
      .DOUT_VLD  (DOUT_VLD),
      .BUSY      (BUSY),
      .SP_OUT    (SP_OUT),
      .DBG_STATE (DBG_STATE)
   );

   // ---------------- scratch RAM model ----------------
   logic [DW-1:0] mem [256];
   always @(posedge CLK) begin
      if (SCR_RE) SCR_DATA <= mem[SCR_ADDR];
   end

   // ---------------- scoreboard ----------------
   int vectors = 0;
   int miscompares = 0;
   logic [13:0] exp_q[$];   // {one-hot dest, data}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [1:0] dest, input logic [DW-1:0] data);
      logic [3:0] oh;
      oh = 4'b0001 << dest;
      exp_q.push_back({oh, data});
   endtask

   // Monitor: every valid pulse must be one-hot and match the queue head.
   always @(negedge CLK) begin
      if (DOUT_VLD != 4'b0000) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_dlv: got vld=%b dout=0x%0h expected no delivery", DOUT_VLD, DOUT);
         end else begin
            logic [13:0] e;
            e = exp_q.pop_front();
            if ({DOUT_VLD, DOUT} !== e) begin
               miscompares++;
               $display("FAIL dlv: got vld=%b dout=0x%0h expected vld=%b dout=0x%0h",
                        DOUT_VLD, DOUT, e[13:10], e[9:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] dest, input logic [DW-1:0] exp_data);
      REQ      = 1'b1;
      REQ_OP   = op;
      REQ_DEST = dest;
      push_exp(dest, exp_data);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h3C] = 10'h2A5;
      mem[8'hFF] = 10'h155;
      mem[8'h00] = 10'h0AB;
      mem[8'h42] = 10'h3F0;
      mem[8'h10] = 10'h101;
      mem[8'h11] = 10'h202;
      mem[8'h12] = 10'h303;
      mem[8'h13] = 10'h3FF;
      mem[8'h20] = 10'h0F0;

      // Reset
      RST = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      check("rst_scr_addr", 32'(SCR_ADDR), 32'h0);
      check("rst_scr_re",   32'(SCR_RE),   32'h0);
      check("rst_dout",     32'(DOUT),     32'h0);
      check("rst_vld",      32'(DOUT_VLD), 32'h0);
      check("rst_busy",     32'(BUSY),     32'h0);
      check("rst_sp",       32'(SP_OUT),   32'h0);

      // RD_IMM 0x3C -> dest 2
      IMM_ADDR = 8'h3C;
      issue(2'd0, 2'd2, 10'h2A5);
      tick();                                     // E0: RD
      REQ = 1'b0;
      check("imm_addr", 32'(SCR_ADDR), 32'h3C);
      check("imm_re1",  32'(SCR_RE),   32'h1);
      check("imm_busy1", 32'(BUSY),    32'h1);
      tick();                                     // E1: DLV
      check("imm_re0",  32'(SCR_RE),   32'h0);
      check("imm_vld_early", 32'(DOUT_VLD), 32'h0);
      check("imm_busy2", 32'(BUSY),    32'h1);
      tick();                                     // E2: pulse
      check("imm_dout", 32'(DOUT),     32'h2A5);
      check("imm_vld",  32'(DOUT_VLD), 32'h4);
      check("imm_busy3", 32'(BUSY),    32'h0);
      tick();
      check("imm_vld_clr", 32'(DOUT_VLD), 32'h0);
      check("imm_dout_hold", 32'(DOUT), 32'h2A5);

      // SP load 0xFF, POP dest 1 -> wraps to 0x00
      SP_LD = 1'b1; SP_DIN = 8'hFF;
      tick();
      SP_LD = 1'b0;
      check("sp_ld_ff", 32'(SP_OUT), 32'hFF);
      issue(2'd2, 2'd1, 10'h155);
      tick();                                     // RD
      REQ = 1'b0;
      check("pop_addr", 32'(SCR_ADDR), 32'hFF);
      check("pop_sp_rd", 32'(SP_OUT), 32'hFF);
      tick();                                     // DLV
      check("pop_sp_wrap", 32'(SP_OUT), 32'h00);
      tick();                                     // pulse
      check("pop_vld", 32'(DOUT_VLD), 32'h2);
      tick();

      // POP with SP_DECR during RD -> SP unchanged
      issue(2'd2, 2'd3, 10'h0AB);
      tick();                                     // RD
      REQ = 1'b0;
      SP_DECR = 1'b1;
      check("pop_dec_addr", 32'(SCR_ADDR), 32'h00);
      tick();                                     // DLV
      SP_DECR = 1'b0;
      check("pop_dec_sp", 32'(SP_OUT), 32'h00);
      tick();
      check("pop_dec_vld", 32'(DOUT_VLD), 32'h8);
      tick();

      // PEEK at SP=0x42
      SP_LD = 1'b1; SP_DIN = 8'h42;
      tick();
      SP_LD = 1'b0;
      issue(2'd3, 2'd0, 10'h3F0);
      tick();
      REQ = 1'b0;
      check("peek_addr", 32'(SCR_ADDR), 32'h42);
      tick();
      check("peek_sp_dlv", 32'(SP_OUT), 32'h42);
      tick();
      check("peek_vld", 32'(DOUT_VLD), 32'h1);
      check("peek_sp", 32'(SP_OUT), 32'h42);
      tick();

      // RD_REG with REQ held high: one acceptance every 3 cycles
      REG_ADDR = 8'h10;
      issue(2'd1, 2'd0, mem[8'h10]);
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] a;
         logic [3:0]    oh;
         a  = 8'h10 + AW'(i);
         oh = 4'b0001 << (i % 4);
         tick();                                  // RD
         check("bb_re",   32'(SCR_RE),   32'h1);
         check("bb_addr", 32'(SCR_ADDR), 32'(a));
         if (i == 3) begin
            REQ = 1'b0;
         end else begin
            REG_ADDR = a + 8'h01;
            REQ_DEST = 2'(i + 1);
            push_exp(2'(i + 1), mem[a + 8'h01]);
         end
         tick();                                  // DLV: must not re-accept
         check("bb_busy_re", 32'(SCR_RE), 32'h0);
         check("bb_busy_addr", 32'(SCR_ADDR), 32'(a));
         check("bb_busy", 32'(BUSY), 32'h1);
         tick();                                  // pulse / IDLE
         check("bb_vld", 32'(DOUT_VLD), 32'(oh));
         check("bb_idle", 32'(BUSY), 32'h0);
      end
      tick();
      check("bb_no_extra", 32'(SCR_RE), 32'h0);

      // Reset during DLV of a POP: no pulse, SP increment reverted by reset
      SP_LD = 1'b1; SP_DIN = 8'h20;
      tick();
      SP_LD = 1'b0;
      REQ = 1'b1; REQ_OP = 2'd2; REQ_DEST = 2'd2;  // aborted: nothing pushed
      tick();                                     // RD
      REQ = 1'b0;
      tick();                                     // DLV
      check("abort_sp_dlv", 32'(SP_OUT), 32'h21);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_vld",  32'(DOUT_VLD), 32'h0);
      check("abort_sp",   32'(SP_OUT),   32'h0);
      check("abort_busy", 32'(BUSY),     32'h0);
      check("abort_re",   32'(SCR_RE),   32'h0);
      check("abort_addr", 32'(SCR_ADDR), 32'h0);
      check("abort_dout", 32'(DOUT),     32'h0);
      tick();
      check("abort_vld2", 32'(DOUT_VLD), 32'h0);

      // SP wrap on decrement, and load beating decrement
      SP_DECR = 1'b1;
      tick();
      SP_DECR = 1'b0;
      check("sp_dec_wrap", 32'(SP_OUT), 32'hFF);
      SP_LD = 1'b1; SP_DIN = 8'h80; SP_DECR = 1'b1;
      tick();
      SP_LD = 1'b0; SP_DECR = 1'b0;
      check("sp_ld_prio", 32'(SP_OUT), 32'h80);

      repeat (4) tick();
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_scr_read_ctrl

// File: doc/scr_read_ctrl.md
# scr_read_ctrl

Read-side controller for the MCU scratch RAM. It accepts a read request, generates the scratch-RAM address from an immediate, a register value or the stack pointer, and issues a synchronous read. It then demultiplexes the returned word to one of four destinations using a one-hot valid strobe. It owns the stack pointer (SP), so POP reads and post-increments here; the write path's PUSH only signals decrements.

## Interface
- DATA_W, 10, scratch-RAM word width
- ADDR_W, 8, scratch-RAM address width; SP width
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  1  read request, sampled only in IDLE
- REQ_OP  in  2  address source: 0 RD_IMM (IMM_ADDR), 1 RD_REG (REG_ADDR), 2 POP (SP, then SP+1), 3 PEEK (SP, no change)
- REQ_DEST  in  2  destination index 0..3 for returned data
- IMM_ADDR  in  ADDR_W  immediate address
- REG_ADDR  in  ADDR_W  register-sourced address
- SP_LD  in  1  load SP from SP_DIN
- SP_DIN  in  ADDR_W  SP load value
- SP_DECR  in  1  PUSH decrement strobe from the write path
- SCR_ADDR  out  ADDR_W  scratch-RAM read address, registered
- SCR_RE  out  1  scratch-RAM read enable, registered
- SCR_DATA  in  DATA_W  RAM read data, valid the cycle after SCR_RE
- DOUT  out  DATA_W  delivered data, registered
- DOUT_VLD  out  4  one-hot valid, bit = REQ_DEST, single-cycle pulse
- BUSY  out  1  high in RD and DLV; REQ ignored while high
- SP_OUT  out  ADDR_W  current SP

## Operation
- FSM states: IDLE, RD, DLV.
- IDLE:
  - If REQ=1, latch op and dest, select the address per REQ_OP, register it onto SCR_ADDR, set SCR_RE=1, and go to RD.
  - If REQ=0, stay in IDLE.
- RD: SCR_RE drops to 0. If op=POP, SP increments at the end of this cycle. Go to DLV.
- DLV: at the clock edge, DOUT<=SCR_DATA, DOUT_VLD<=1<<dest, go to IDLE.
- DOUT_VLD clears to 0 the cycle after the pulse. DOUT holds its value until the next delivery.
- SP update priority:
  - SP_LD wins.
  - Otherwise the net of (POP increment) and SP_DECR applies; both together leave SP unchanged.
  - Arithmetic is modulo 2^ADDR_W: 0xFF+1→0x00, 0x00−1→0xFF.
- SP_LD and SP_DECR act in any state. A POP address uses SP as sampled in IDLE.
- Reset values: state IDLE, SP=0, SCR_ADDR=0, SCR_RE=0, DOUT=0, DOUT_VLD=0, BUSY=0.
- Reset mid-operation aborts the read with no DOUT_VLD pulse. A POP's SP increment is lost if reset occurs before the end of RD.

## Timing
- REQ sampled at edge E0 → SCR_RE=1 and SCR_ADDR valid in cycle E0..E1 (RD).
- RAM data valid in DLV (E1..E2). DOUT and DOUT_VLD valid E2..E3.
- Throughput: one request per 3 cycles.
- A REQ held high in the cycle DOUT_VLD pulses (IDLE) is accepted, so back-to-back requests occur every 3 cycles.
- BUSY is registered: 1 from E0 to E2, 0 in the DOUT_VLD cycle.
- SP after POP updates at edge E1, so SP_OUT shows the new value during DLV.

## Structure
- Shared package scr_pkg holds:
  - scr_op_t enum (RD_IMM, RD_REG, POP, PEEK)
  - rd_state_t enum (IDLE, RD, DLV)
  - SCR_DATA_W=10, SCR_ADDR_W=8 constants, shared with the write-path blocks
- One sub-module: scr_sp_reg, holding the SP register with load/increment/decrement priority and wrap.
- The FSM, address select and demux live in the top module.

## Test plan
- Reset, then RD_IMM with IMM_ADDR=0x3C, dest=2, RAM returns 0x2A5 → SCR_ADDR=0x3C, SCR_RE one cycle, DOUT=0x2A5, DOUT_VLD=4'b0100 exactly 3 cycles after REQ.
- SP_LD with SP_DIN=0xFF, then POP with dest=1 → read at 0xFF, SP_OUT=0x00 after RD, DOUT_VLD=4'b0010.
- POP with SP_DECR asserted during RD → SP unchanged. PEEK → SP unchanged and address = SP.
- REQ held high continuously with RD_REG (REG_ADDR=0x10, 0x11, ...) → accepted every 3 cycles. No REQ accepted while BUSY=1, and DOUT_VLD pulses never overlap.
- RST asserted during DLV of a POP → no DOUT_VLD pulse; all outputs return to reset values, with SP=0 and BUSY=0 the next cycle.
- SP=0x00 with SP_DECR while IDLE → SP_OUT=0xFF; simultaneous SP_LD(0x80) and SP_DECR → SP_OUT=0x80.
